// File: rtl/snake_timing_pkg.sv
// Shared timing types and defaults for the snake core scheduler.
//   sched_state_e : scheduler FSM states (PAUSE, RUN, STEP)
//   *_DEF         : default timing constants for a 100 MHz clock
//   max_level()   : highest speed level before the period hits its floor
package snake_timing_pkg;

    typedef enum logic [1:0] {
        PAUSE = 2'd0,
        RUN   = 2'd1,
        STEP  = 2'd2
    } sched_state_e;

    localparam int unsigned PIX_DIV_DEF   = 4;
    localparam int unsigned TICK_BASE_DEF = 12_500_000;
    localparam int unsigned TICK_STEP_DEF = 1_250_000;
    localparam int unsigned TICK_MIN_DEF  = 2_500_000;
    localparam int unsigned CNT_W_DEF     = 24;
    localparam int unsigned LEVEL_W       = 4;

    // Number of period reductions that fit between the base period and the floor.
    function automatic int unsigned max_level(input int unsigned base,
                                              input int unsigned step_sz,
                                              input int unsigned floor_p);
        return (base - floor_p) / step_sz;
    endfunction

endpackage

// File: rtl/enable_divider.sv
// Generic modulo-N counter producing a terminal-count pulse.
//   clk, rst_n : clock, async active-low reset
//   en         : count this cycle
//   clear      : force count to 0 (wins over en)
//   limit      : modulus N (>= 1); may change at runtime
//   tc_c       : combinational terminal count, high while en and count >= N-1
module enable_divider #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clear,
    input  logic [W-1:0] limit,
    output logic         tc_c
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // >= rather than == so a limit that shrinks below the count wraps at once.
    always_comb begin
        tc_c  = en && (cnt_q >= (limit - W'(1)));
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tc_c ? '0 : (cnt_q + W'(1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/game_tick_sched.sv
// Timing scheduler for the snake core: single-clock enables for the pixel
// datapath and snake movement, plus pause / single-step / speed-up sequencing.
//   clock100    : 100 MHz system clock
//   reset_n     : async active-low reset
//   pause       : level, 1 requests PAUSE
//   step        : pulse, one tick while paused
//   grow        : pulse, food eaten (raises speed level when enabled)
//   pix_en      : one-cycle enable every PIX_DIV cycles
//   game_tick   : one-cycle enable advancing the snake one cell
//   speed_level : current speed level 0..MAX_LEVEL
//   running     : 1 while in RUN
// Optional feature macro: GAME_SPEEDUP_EN (grow-driven speed levels).
module game_tick_sched
    import snake_timing_pkg::*;
#(
    parameter int unsigned PIX_DIV   = PIX_DIV_DEF,
    parameter int unsigned TICK_BASE = TICK_BASE_DEF,
    parameter int unsigned TICK_STEP = TICK_STEP_DEF,
    parameter int unsigned TICK_MIN  = TICK_MIN_DEF,
    parameter int unsigned CNT_W     = CNT_W_DEF
) (
    input  logic               clock100,
    input  logic               reset_n,
    input  logic               pause,
    input  logic               step,
    input  logic               grow,
    output logic               pix_en,
    output logic               game_tick,
    output logic [LEVEL_W-1:0] speed_level,
    output logic               running
);

    localparam int unsigned PIX_W = $clog2(PIX_DIV + 1);

    sched_state_e state_q, state_d;
    logic         pix_en_q, pix_en_d;
    logic         game_tick_q, game_tick_d;
    logic         running_q, running_d;
    logic         pix_tc_c;
    logic         tick_tc_c;
    logic [CNT_W-1:0] period;

`ifdef GAME_SPEEDUP_EN
    localparam int unsigned PER_W     = CNT_W + 4;
    localparam int unsigned MAX_LEVEL = max_level(TICK_BASE, TICK_STEP, TICK_MIN);

    logic [LEVEL_W-1:0] level_q, level_d;
    logic [PER_W-1:0]   dec;
    logic [PER_W-1:0]   period_full;

    // Saturating speed level, advanced by grow in any state.
    always_comb begin
        level_d = level_q;
        if (grow && (level_q < LEVEL_W'(MAX_LEVEL))) begin
            level_d = level_q + LEVEL_W'(1);
        end
    end

    // Period at full width, floored at TICK_MIN; result always fits CNT_W.
    always_comb begin
        dec = PER_W'(level_q) * PER_W'(TICK_STEP);
        if ((dec + PER_W'(TICK_MIN)) > PER_W'(TICK_BASE)) begin
            period_full = PER_W'(TICK_MIN);
        end else begin
            period_full = PER_W'(TICK_BASE) - dec;
        end
    end

    always_ff @(posedge clock100 or negedge reset_n) begin
        if (!reset_n) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    assign period      = CNT_W'(period_full);
    assign speed_level = level_q;
`else
    localparam int unsigned UNUSED_CFG = TICK_STEP + TICK_MIN;
    logic unused_grow;

    assign unused_grow = grow;
    assign period      = CNT_W'(TICK_BASE);
    assign speed_level = '0;
`endif

    // Free-running pixel enable divider.
    enable_divider #(
        .W (PIX_W)
    ) u_pix_div (
        .clk   (clock100),
        .rst_n (reset_n),
        .en    (1'b1),
        .clear (1'b0),
        .limit (PIX_W'(PIX_DIV)),
        .tc_c  (pix_tc_c)
    );

    // Game tick divider: counts only in RUN, restarted by a single step.
    enable_divider #(
        .W (CNT_W)
    ) u_tick_div (
        .clk   (clock100),
        .rst_n (reset_n),
        .en    (state_q == RUN),
        .clear (state_q == STEP),
        .limit (period),
        .tc_c  (tick_tc_c)
    );

    // Next state and registered-output inputs.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            PAUSE: begin
                if (!pause) begin
                    state_d = RUN;
                end else if (step) begin
                    state_d = STEP;
                end
            end
            RUN: begin
                if (pause) begin
                    state_d = PAUSE;
                end
            end
            STEP: begin
                state_d = pause ? PAUSE : RUN;
            end
            default: state_d = PAUSE;
        endcase

        pix_en_d    = pix_tc_c;
        // The step tick is registered on entry so it appears while in STEP.
        game_tick_d = tick_tc_c || (state_d == STEP);
        running_d   = (state_d == RUN);
    end

    always_ff @(posedge clock100 or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= PAUSE;
            pix_en_q    <= 1'b0;
            game_tick_q <= 1'b0;
            running_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pix_en_q    <= pix_en_d;
            game_tick_q <= game_tick_d;
            running_q   <= running_d;
        end
    end

    assign pix_en    = pix_en_q;
    assign game_tick = game_tick_q;
    assign running   = running_q;

endmodule

// File: tb/tb_game_tick_sched.sv
// Self-checking bench for game_tick_sched with small timing parameters.
module tb_game_tick_sched;

    localparam int unsigned PIX_DIV   = 4;
    localparam int unsigned TICK_BASE = 20;
    localparam int unsigned TICK_STEP = 4;
    localparam int unsigned TICK_MIN  = 8;
    localparam int unsigned CNT_W     = 24;
    localparam int          MAX_LEVEL = (TICK_BASE - TICK_MIN) / TICK_STEP;
`ifdef GAME_SPEEDUP_EN
    localparam bit SPEEDUP = 1'b1;
`else
    localparam bit SPEEDUP = 1'b0;
`endif

    localparam int M_PAUSED   = 0;
    localparam int M_RUNNING  = 1;
    localparam int M_STEPPING = 2;

    logic       clock100 = 1'b0;
    logic       reset_n  = 1'b0;
    logic       pause    = 1'b0;
    logic       step     = 1'b0;
    logic       grow     = 1'b0;
    logic       pix_en;
    logic       game_tick;
    logic       running;
    logic [3:0] speed_level;

    int checks = 0;
    int errors = 0;

    // Reference model: cycles since reset, mode, cycles into current period, level.
    int   m_cycles, m_mode, m_count, m_level;
    logic e_pix, e_tick, e_run;

    always #5 clock100 = ~clock100;

    game_tick_sched #(
        .PIX_DIV   (PIX_DIV),
        .TICK_BASE (TICK_BASE),
        .TICK_STEP (TICK_STEP),
        .TICK_MIN  (TICK_MIN),
        .CNT_W     (CNT_W)
    ) dut (
        .clock100    (clock100),
        .reset_n     (reset_n),
        .pause       (pause),
        .step        (step),
        .grow        (grow),
        .pix_en      (pix_en),
        .game_tick   (game_tick),
        .speed_level (speed_level),
        .running     (running)
    );

    function automatic int model_period(input int lvl);
        int p;
        p = int'(TICK_BASE) - lvl * int'(TICK_STEP);
        return (p < int'(TICK_MIN)) ? int'(TICK_MIN) : p;
    endfunction

    function void model_reset();
        m_cycles = 0; m_mode = M_PAUSED; m_count = 0; m_level = 0;
        e_pix = 1'b0; e_tick = 1'b0; e_run = 1'b0;
    endfunction

    // One clock edge of the behavioural model, using the inputs sampled now.
    function void model_edge();
        int per;
        per      = model_period(m_level);
        m_cycles = m_cycles + 1;
        e_pix    = ((m_cycles % int'(PIX_DIV)) == 0);
        e_tick   = 1'b0;
        if (m_mode == M_PAUSED) begin
            if (!pause) m_mode = M_RUNNING;
            else if (step) begin m_mode = M_STEPPING; e_tick = 1'b1; end
        end else if (m_mode == M_RUNNING) begin
            m_count = m_count + 1;
            if (m_count >= per) begin e_tick = 1'b1; m_count = 0; end
            if (pause) m_mode = M_PAUSED;
        end else begin
            m_count = 0;
            m_mode  = pause ? M_PAUSED : M_RUNNING;
        end
        if (SPEEDUP && grow && (m_level < MAX_LEVEL)) m_level = m_level + 1;
        e_run = (m_mode == M_RUNNING);
    endfunction

    task automatic cyc();
        @(posedge clock100);
        model_edge();
        @(negedge clock100);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        model_reset();
        @(negedge clock100);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        pause = 1'b1;
        reset_n = 1'b0;
        #3;
        checks++;
        if ({pix_en, game_tick, running, speed_level} !== 7'd0) begin
            errors++;
            $display("FAIL reset_held: got pix=%b tick=%b run=%b lvl=%0d, expected all 0",
                     pix_en, game_tick, running, speed_level);
        end
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            cyc();
            checks++;
            if ({pix_en, game_tick, running} !== {((i % 4) == 0), 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL reset_paused cyc=%0d: got pix=%b tick=%b run=%b, expected pix=%b tick=0 run=0",
                         i, pix_en, game_tick, running, ((i % 4) == 0));
            end
        end
    endtask

    task automatic test_run();
        int tick_at[$];
        pause = 1'b0;
        do_reset();
        for (int i = 1; i <= 65; i++) begin
            cyc();
            if (game_tick) tick_at.push_back(i);
            checks++;
            if ({pix_en, game_tick, running, speed_level} !== {e_pix, e_tick, e_run, 4'(m_level)}) begin
                errors++;
                $display("FAIL run_model cyc=%0d: got pix=%b tick=%b run=%b lvl=%0d, expected pix=%b tick=%b run=%b lvl=%0d",
                         i, pix_en, game_tick, running, speed_level, e_pix, e_tick, e_run, m_level);
            end
            if (i == 1) begin
                checks++;
                if (running !== 1'b1) begin
                    errors++;
                    $display("FAIL run_enter: got running=%b, expected 1", running);
                end
            end
        end
        checks++;
        if (tick_at.size() != 3 || tick_at[0] != 21 || tick_at[1] != 41 || tick_at[2] != 61) begin
            errors++;
            $display("FAIL run_ticks: got %0d ticks first=%0d, expected ticks at 21,41,61",
                     tick_at.size(), (tick_at.size() > 0) ? tick_at[0] : -1);
        end
    endtask

    task automatic test_pause();
        int n;
        int paused_ticks;
        pause = 1'b0;
        do_reset();
        for (int i = 0; i < 31; i++) cyc();
        pause = 1'b1;
        paused_ticks = 0;
        for (int i = 0; i < 50; i++) begin
            cyc();
            if (game_tick) paused_ticks++;
            checks++;
            if ({pix_en, game_tick, running} !== {e_pix, e_tick, e_run}) begin
                errors++;
                $display("FAIL pause_model i=%0d: got pix=%b tick=%b run=%b, expected pix=%b tick=%b run=%b",
                         i, pix_en, game_tick, running, e_pix, e_tick, e_run);
            end
        end
        checks++;
        if (paused_ticks != 0) begin
            errors++;
            $display("FAIL pause_no_tick: got %0d ticks while paused, expected 0", paused_ticks);
        end
        pause = 1'b0;
        n = 0;
        do begin cyc(); n++; end while (!game_tick && n < 60);
        checks++;
        if (n != 10) begin
            errors++;
            $display("FAIL pause_resume: got tick after %0d cycles, expected 10", n);
        end
    endtask

    task automatic test_step();
        int ticks;
        pause = 1'b1;
        do_reset();
        for (int i = 0; i < 5; i++) cyc();
        ticks = 0;
        for (int p = 0; p < 2; p++) begin
            step = 1'b1;
            cyc();
            step = 1'b0;
            if (game_tick) ticks++;
            checks++;
            if ({game_tick, running} !== 2'b10) begin
                errors++;
                $display("FAIL step_pulse%0d: got tick=%b run=%b, expected tick=1 run=0", p, game_tick, running);
            end
            for (int i = 0; i < 9; i++) begin
                cyc();
                if (game_tick) ticks++;
                checks++;
                if (running !== 1'b0) begin
                    errors++;
                    $display("FAIL step_running%0d: got running=%b, expected 0", p, running);
                end
            end
        end
        checks++;
        if (ticks != 2) begin
            errors++;
            $display("FAIL step_count: got %0d ticks, expected 2", ticks);
        end
    endtask

    task automatic test_grow_mid();
        int n;
        pause = 1'b0;
        do_reset();
        n = 0;
        do begin cyc(); n++; end while (!game_tick && n < 60);
        for (int i = 0; i < 17; i++) cyc();
        grow = 1'b1;
        cyc();
        grow = 1'b0;
        n = 0;
        do begin cyc(); n++; end while (!game_tick && n < 60);
        checks++;
        if (n != (SPEEDUP ? 1 : 2)) begin
            errors++;
            $display("FAIL grow_mid_tick: got tick after %0d cycles, expected %0d", n, SPEEDUP ? 1 : 2);
        end
        n = 0;
        do begin cyc(); n++; end while (!game_tick && n < 60);
        checks++;
        if (n != (SPEEDUP ? 16 : 20)) begin
            errors++;
            $display("FAIL grow_mid_interval: got %0d, expected %0d", n, SPEEDUP ? 16 : 20);
        end
    endtask

    task automatic test_grow_sat();
        int n;
        pause = 1'b0;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            grow = 1'b1;
            cyc();
            grow = 1'b0;
            cyc();
        end
        checks++;
        if (speed_level !== (SPEEDUP ? 4'd3 : 4'd0)) begin
            errors++;
            $display("FAIL grow_sat_level: got %0d, expected %0d", speed_level, SPEEDUP ? 3 : 0);
        end
        n = 0;
        do begin cyc(); n++; end while (!game_tick && n < 60);
        for (int k = 0; k < 2; k++) begin
            n = 0;
            do begin cyc(); n++; end while (!game_tick && n < 60);
            checks++;
            if (n != (SPEEDUP ? 8 : 20)) begin
                errors++;
                $display("FAIL grow_sat_interval%0d: got %0d, expected %0d", k, n, SPEEDUP ? 8 : 20);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        pause = 1'b0;
        do_reset();
        grow = 1'b1;
        cyc();
        cyc();
        grow = 1'b0;
        n = 0;
        do begin cyc(); n++; end while (!game_tick && n < 60);
        checks++;
        if (game_tick !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_pre: got tick=%b, expected 1", game_tick);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({pix_en, game_tick, running, speed_level} !== 7'd0) begin
            errors++;
            $display("FAIL reset_mid_clear: got pix=%b tick=%b run=%b lvl=%0d, expected all 0",
                     pix_en, game_tick, running, speed_level);
        end
        model_reset();
        @(negedge clock100);
        reset_n = 1'b1;
        n = 0;
        do begin cyc(); n++; end while (!game_tick && n < 60);
        checks++;
        if (n != 21 || speed_level !== 4'd0) begin
            errors++;
            $display("FAIL reset_mid_restart: got first tick at %0d lvl=%0d, expected 21 lvl=0", n, speed_level);
        end
    endtask

    task automatic test_random();
        pause = 1'b1;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) pause = ~pause;
            step = ($urandom_range(0, 5) == 0);
            grow = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 799) == 0) do_reset();
            cyc();
            checks++;
            if ({pix_en, game_tick, running, speed_level} !== {e_pix, e_tick, e_run, 4'(m_level)}) begin
                errors++;
                $display("FAIL random_model i=%0d: got pix=%b tick=%b run=%b lvl=%0d, expected pix=%b tick=%b run=%b lvl=%0d",
                         i, pix_en, game_tick, running, speed_level, e_pix, e_tick, e_run, m_level);
            end
        end
        step = 1'b0;
        grow = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_run();
        test_pause();
        test_step();
        test_grow_mid();
        test_grow_sat();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/game_tick_sched.md
# game_tick_sched

Timing scheduler for the snake core. It runs on the single 100 MHz clock and produces single-cycle clock enables in place of divided ripple clocks: `pix_en` for the 25 MHz VGA pixel datapath, and `game_tick` for snake movement. It also sequences pause, single-step and speed-up, so the game logic and VGA logic stay in one clock domain.

## Interface
Parameters:
- `PIX_DIV`, 4: clock100 cycles per pixel enable.
- `TICK_BASE`, 12_500_000: game-tick period at speed level 0, in cycles.
- `TICK_STEP`, 1_250_000: period reduction per speed level.
- `TICK_MIN`, 2_500_000: floor on the game-tick period.
- `CNT_W`, 24: tick counter width; must satisfy 2^CNT_W > TICK_BASE.

Ports:
- `clock100` in 1: system clock. Single clock domain.
- `reset_n` in 1: asynchronous, active-low reset.
- `pause` in 1: level input. 1 requests the paused state.
- `step` in 1: single-cycle pulse. Requests one tick while paused.
- `grow` in 1: single-cycle pulse, asserted when food is eaten.
- `pix_en` out 1: one-cycle enable, asserted every PIX_DIV cycles.
- `game_tick` out 1: one-cycle enable that advances the snake one cell.
- `speed_level` out 4: current speed level, 0..MAX_LEVEL.
- `running` out 1: 1 when the state is RUN.

## Operation
- MAX_LEVEL = (TICK_BASE − TICK_MIN) / TICK_STEP.
- period = max(TICK_BASE − speed_level·TICK_STEP, TICK_MIN), computed at CNT_W+4 bits with no truncation.
- Pixel counter runs free in every state:
  - `pix_en` = 1 when the counter equals PIX_DIV−1; the counter then wraps to 0.
  - It is never paused or stepped.
- FSM states: PAUSE, RUN, STEP. Reset state is PAUSE.
- PAUSE:
  - Tick counter is held.
  - If `pause`=0, go to RUN.
  - Else if `step`=1, go to STEP.
- RUN:
  - Tick counter increments.
  - When tick_cnt ≥ period−1: `game_tick`=1 and tick_cnt wraps to 0.
  - If `pause`=1, go to PAUSE. The counter increment and any tick in that cycle still occur.
  - `step` is ignored.
- STEP:
  - Lasts exactly one cycle. `game_tick`=1 and tick_cnt is cleared to 0.
  - Next state is PAUSE if `pause`=1, else RUN.
- `pause`=1 and `step`=1 in the same cycle in RUN: go to PAUSE, no extra tick.
- `step` pulses arriving in STEP are dropped.
- `grow` (feature enabled): `speed_level` increments, saturating at MAX_LEVEL. This applies in every state.
- The ≥ comparison above handles a period that shrinks below the current count. An immediate tick and wrap occurs in the next RUN cycle; no counter overrun.
- `grow` in the same cycle as a wrap: the tick is issued and the new period applies from the next count.

## Timing
- Reset values: `pix_en`=0, `game_tick`=0, `speed_level`=0, `running`=0, both counters 0, state PAUSE.
- All outputs are registered.
- `pix_en` first asserts on the PIX_DIV-th rising edge after `reset_n` deasserts, then every PIX_DIV cycles.
- Pause → run: `running`=1 one edge after `pause`=0 is sampled.
- First tick after entering RUN from reset: period cycles later.
- Step latency: `game_tick` is high in the cycle after `step` is sampled, for exactly 1 cycle.
- Reset asserted mid-operation clears everything immediately. Nothing is resumed.

## Configuration
- Macro: `GAME_SPEEDUP_EN`.
- Defined: `grow` drives `speed_level` as described.
- Undefined:
  - `speed_level` is constant 0 and `grow` is ignored.
  - period is constant TICK_BASE.
  - The level register and period arithmetic are not synthesized.

## Structure
- Package `snake_timing_pkg` holds:
  - the FSM state enum (PAUSE, RUN, STEP);
  - default timing constants;
  - the MAX_LEVEL function.
- Sub-module `enable_divider`:
  - generic modulo-N counter with `en` input, `clear` input and terminal-count pulse;
  - used for `pix_en`, and for the tick counter with a runtime period input.

## Test plan
Bench parameters: PIX_DIV=4, TICK_BASE=20, TICK_STEP=4, TICK_MIN=8, so MAX_LEVEL=3.
- Release reset with `pause`=0 → `pix_en` high on cycles 4, 8, 12; `running`=1 at cycle 1; first `game_tick` 20 cycles into RUN, then every 20 cycles.
- Hold `pause`=1 for 50 cycles mid-period, then release → no `game_tick` while paused; the tick arrives after the remaining count, not a full period.
- In PAUSE, pulse `step` twice, 10 cycles apart → exactly two single-cycle `game_tick`s, each one cycle after its pulse; `running` stays 0.
- Five `grow` pulses → `speed_level` reaches 3 and stays there; period becomes 8; next tick intervals are 8 cycles.
- `grow` at tick_cnt=17, moving period 20→16 → `game_tick` on the next cycle, then 16-cycle intervals.
- Assert `reset_n` low for 1 cycle during a run → all outputs 0 and state PAUSE immediately; `speed_level` returns to 0.
